// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, h/v counters, registered sync/blank/position/strobes.
// Optional frame counter behind VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen #(
  parameter int CNT_W    = 10,
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit H_POL    = 1'b0,
  parameter bit V_POL    = 1'b0
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  parameter int FRAME_W  = 8
`endif
) (
  input  logic             pix_clk,
  input  logic             reset,
  output logic             p_tick,
  output logic             display_on,
  output logic             Hsync,
  output logic             Vsync,
  output logic [CNT_W-1:0] x_pos,
  output logic [CNT_W-1:0] y_pos,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_W-1:0] frame_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] HS_LEN   = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VS_LEN   = CNT_W'(V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] h_cnt, v_cnt;
  logic [CNT_W-1:0] h_nxt, v_nxt;
  logic [CNT_W-1:0] h_off, v_off;
  logic             tick_int;

  assign tick_int = (div_cnt == DIV_LAST);

  // Position the counters take on the coming tick; all decode is done on this.
  always_comb begin
    h_nxt = h_cnt + CNT_W'(1);
    v_nxt = v_cnt;
    if (h_cnt == H_LAST) begin
      h_nxt = '0;
      v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
    end
  end

  // Unsigned wrap turns the sync window test into a single compare.
  assign h_off = h_nxt - HS_BEG;
  assign v_off = v_nxt - VS_BEG;

  always_ff @(posedge pix_clk) begin
    if (reset) begin
      div_cnt     <= '0;
      h_cnt       <= H_LAST;
      v_cnt       <= V_LAST;
      p_tick      <= 1'b0;
      display_on  <= 1'b0;
      Hsync       <= ~H_POL;
      Vsync       <= ~V_POL;
      x_pos       <= '0;
      y_pos       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= tick_int ? '0 : div_cnt + DIV_W'(1);
      p_tick      <= tick_int;
      line_start  <= tick_int && (h_nxt == '0);
      frame_start <= tick_int && (h_nxt == '0) && (v_nxt == '0);
      if (tick_int) begin
        h_cnt      <= h_nxt;
        v_cnt      <= v_nxt;
        x_pos      <= h_nxt;
        y_pos      <= v_nxt;
        display_on <= (h_nxt < H_ACT) && (v_nxt < V_ACT);
        Hsync      <= (h_off < HS_LEN) ? H_POL : ~H_POL;
        Vsync      <= (v_off < VS_LEN) ? V_POL : ~V_POL;
      end
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  // Starts at all-ones so the first frame_start lands it on zero.
  always_ff @(posedge pix_clk) begin
    if (reset) begin
      frame_cnt <= '1;
    end else if (tick_int && (h_nxt == '0) && (v_nxt == '0)) begin
      frame_cnt <= frame_cnt + FRAME_W'(1);
    end
  end
`else
  // No frame counter in this build.
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-mode instance and a tiny fast-divider mode, both
// compared every cycle against an arithmetic model derived from cycles since reset release.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic       p_tick_a, disp_a, hs_a, vs_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic       p_tick_b, disp_b, hs_b, vs_b, ls_b, fs_b;
  logic [3:0] x_b, y_b;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [7:0] fc_a;
  logic [1:0] fc_b;
`endif

  vga_timing_gen u_a (
    .pix_clk(clk), .reset(rst_a), .p_tick(p_tick_a), .display_on(disp_a),
    .Hsync(hs_a), .Vsync(vs_a), .x_pos(x_a), .y_pos(y_a),
    .line_start(ls_a), .frame_start(fs_a)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_a)
`endif
  );

  vga_timing_gen #(
    .CNT_W(4), .CLK_DIV(1),
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .FRAME_W(2)
`endif
  ) u_b (
    .pix_clk(clk), .reset(rst_b), .p_tick(p_tick_b), .display_on(disp_b),
    .Hsync(hs_b), .Vsync(vs_b), .x_pos(x_b), .y_pos(y_b),
    .line_start(ls_b), .frame_start(fs_b)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_b)
`endif
  );

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int n_a = 0;
  int n_b = 0;

  typedef struct {
    logic p_tick, disp, hs, vs, ls, fs;
    int   x, y, frames;
  } exp_t;

  // n = rising edges since reset was last seen low-going; pixel k = n/d - 1.
  function automatic exp_t model(int n, int d, int ha, int hf, int hs, int hb,
                                 int va, int vf, int vs, int vb, bit hp, bit vp);
    exp_t e;
    int ht, vt, k, h, v;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    e.p_tick = 1'b0; e.disp = 1'b0; e.hs = ~hp; e.vs = ~vp;
    e.ls = 1'b0; e.fs = 1'b0; e.x = 0; e.y = 0; e.frames = -1;
    if (n > 0 && n / d > 0) begin
      k = n / d - 1;
      h = k % ht;
      v = (k / ht) % vt;
      e.frames = k / (ht * vt);
      e.p_tick = (n % d == 0);
      e.x = h;
      e.y = v;
      e.disp = (h < ha) && (v < va);
      e.hs = (h >= ha + hf && h < ha + hf + hs) ? hp : ~hp;
      e.vs = (v >= va + vf && v < va + vf + vs) ? vp : ~vp;
      e.ls = e.p_tick && (h == 0);
      e.fs = e.p_tick && (h == 0) && (v == 0);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic check_a();
    exp_t e;
    e = model(n_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    chk("a_p_tick", p_tick_a, e.p_tick);
    chk("a_display_on", disp_a, e.disp);
    chk("a_hsync", hs_a, e.hs);
    chk("a_vsync", vs_a, e.vs);
    chk("a_x_pos", x_a, e.x);
    chk("a_y_pos", y_a, e.y);
    chk("a_line_start", ls_a, e.ls);
    chk("a_frame_start", fs_a, e.fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("a_frame_cnt", fc_a, e.frames & 255);
`endif
  endtask

  task automatic check_b();
    exp_t e;
    e = model(n_b, 1, 4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1);
    chk("b_p_tick", p_tick_b, e.p_tick);
    chk("b_display_on", disp_b, e.disp);
    chk("b_hsync", hs_b, e.hs);
    chk("b_vsync", vs_b, e.vs);
    chk("b_x_pos", x_b, e.x);
    chk("b_y_pos", y_b, e.y);
    chk("b_line_start", ls_b, e.ls);
    chk("b_frame_start", fs_b, e.fs);
`ifdef VGA_TIMING_FRAME_CNT_EN
    chk("b_frame_cnt", fc_b, e.frames & 3);
`endif
  endtask

  // One clock: advance the model on the edge, compare on the falling edge.
  task automatic step();
    @(posedge clk);
    n_a = rst_a ? 0 : n_a + 1;
    n_b = rst_b ? 0 : n_b + 1;
    @(negedge clk);
    check_a();
    check_b();
  endtask

  initial begin
    int run_len, rst_len, which;
    rst_a = 1'b1;
    rst_b = 1'b1;
    repeat (3) step();
    chk("reset_hsync_a", hs_a, 1'b1);
    chk("reset_hsync_b", hs_b, 1'b0);

    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (3) step();
    chk("a_no_tick_before_edge4", p_tick_a, 1'b0);
    chk("b_tick_every_cycle", p_tick_b, 1'b1);
    step();
    chk("a_first_tick", p_tick_a, 1'b1);
    chk("a_first_x", x_a, 0);
    chk("a_first_y", y_a, 0);
    chk("a_first_display", disp_a, 1'b1);
    chk("a_first_frame_start", fs_a, 1'b1);

    // Two full default lines plus margin, then the tiny mode frame_start spacing.
    repeat (6500) step();

    repeat (24) begin
      run_len = $urandom_range(40, 2500);
      repeat (run_len) step();
      which   = $urandom_range(0, 1);
      rst_len = $urandom_range(1, 3);
      if (which == 0) rst_a = 1'b1;
      else            rst_b = 1'b1;
      repeat (rst_len) step();
      rst_a = 1'b0;
      rst_b = 1'b0;
    end
    repeat (500) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
